fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 16-bit pipelined processor. It holds the program counter, drives the word address of the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. It handles stall requests from the hazard unit, flush/redirect requests from branch resolution, and halt-instruction detection. The IF/ID register feeds the decode stage.

Parameters:
ADDR_W, 10, instruction word-address width; PC wraps modulo 2^ADDR_W
INST_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset
HALT_OP, 16'hFFFF, instruction encoding that halts fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID this cycle
flush  in  1  branch taken: redirect PC and squash IF/ID
branch_target  in  ADDR_W  redirect address, sampled only when flush=1
pc_to_mem  out  ADDR_W  address to instruction memory (equals PC register)
inst_from_mem  in  INST_W  instruction memory read data, valid in the same cycle as pc_to_mem
ifid_inst  out  INST_W  IF/ID instruction; 0 (NOP) when the slot holds a bubble
ifid_pc1  out  ADDR_W  IF/ID PC+1 of the captured instruction
ifid_valid  out  1  IF/ID holds a real instruction
halted  out  1  high while in state HALT
fetch_count  out  16  count of instructions delivered into IF/ID; saturates at 16'hFFFF

Behaviour:
- Reset, asynchronous and active-high: pc=RESET_PC, ifid_inst=0, ifid_pc1=0, ifid_valid=0, fetch_count=0, state=IDLE, halted=0. Reset asserted mid-operation aborts everything immediately. No output is X after reset.
- pc_to_mem is driven combinationally from the PC register. Memory read is combinational, so the instruction is captured at the next rising edge (1-cycle fetch latency).
- States: IDLE, RUN, HALT.
- IDLE: lasts exactly one cycle after rst deasserts (memory-load settling). PC and IF/ID are held, ifid_valid=0, stall and flush are ignored. Next state is RUN.
- RUN: priority is flush > stall > normal.
  - flush: pc<=branch_target, ifid_inst<=0, ifid_valid<=0, ifid_pc1<=0. This applies even if stall=1 in the same cycle.
  - stall (and no flush): pc, ifid_*, and fetch_count are all held.
  - normal: pc<=pc+1, wrapping from 2^ADDR_W-1 to 0. ifid_inst<=inst_from_mem, ifid_pc1<=pc+1 (wrapped), ifid_valid<=1, fetch_count+=1 (saturating).
  - normal with inst_from_mem==HALT_OP: the halt instruction is captured exactly as in normal, except pc is NOT incremented, and the next state is HALT.
- HALT: halted=1 and pc is held.
  - First non-stall cycle without flush: IF/ID becomes a bubble (ifid_inst=0, ifid_valid=0) and stays a bubble. The halt instruction is therefore passed downstream exactly once.
  - stall: IF/ID is held, so the halt instruction stays in place.
  - flush (an older branch resolves taken): pc<=branch_target, IF/ID is squashed, next state is RUN, halted drops the following cycle.
- fetch_count increments only on cycles where ifid_valid is loaded with 1.
- Unused input bits are ignored. No combinational path exists from stall or flush to pc_to_mem.

Test Plan:
1. Reset then run with memory words 0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444 -> one IDLE cycle with pc_to_mem=0 and ifid_valid=0. Then on successive edges, ifid_inst=16'h1111/2222/3333 with ifid_pc1=1/2/3, and fetch_count=3.
2. stall held for 2 cycles while ifid_inst=16'h2222 -> pc_to_mem stays 2, ifid unchanged, fetch_count unchanged. Deassert stall -> ifid_inst=16'h3333.
3. flush with branch_target=10'h200 asserted together with stall -> next edge gives pc_to_mem=10'h200 and ifid_valid=0. The following edge gives ifid_inst=mem[10'h200] and ifid_pc1=10'h201.
4. PC wrap: redirect to 10'h3FF -> after capture, ifid_pc1=0 and pc_to_mem=0.
5. HALT_OP at address 5 -> ifid_inst=16'hFFFF for exactly one cycle, then a bubble; halted=1; pc_to_mem held at 5. A later flush with target 0 -> state RUN, halted=0, fetch resumes at 0.
6. Assert rst mid-run with pc=7 and fetch_count=7 -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and loads the IF/ID register, with stall, flush/redirect and halt handling.
module fetch_stage #(
    parameter int unsigned        ADDR_W   = 10,
    parameter int unsigned        INST_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [INST_W-1:0]  HALT_OP  = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_to_mem,
    input  logic [INST_W-1:0] inst_from_mem,
    output logic [INST_W-1:0] ifid_inst,
    output logic [ADDR_W-1:0] ifid_pc1,
    output logic              ifid_valid,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc1;
        logic              valid;
    } ifid_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [15:0]       cnt_inc;
    logic              is_halt;

    // Natural truncation gives the modulo-2^ADDR_W wrap.
    assign pc_inc  = pc_q + 1'b1;
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign is_halt = (inst_from_mem == HALT_OP);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                if (flush) begin
                    pc_d   = branch_target;
                    ifid_d = '0;
                end else if (!stall) begin
                    ifid_d.inst  = inst_from_mem;
                    ifid_d.pc1   = pc_inc;
                    ifid_d.valid = 1'b1;
                    cnt_d        = cnt_inc;
                    // Halt is captured once and the PC parks on it.
                    if (is_halt) state_d = S_HALT;
                    else         pc_d    = pc_inc;
                end
            end
            S_HALT: begin
                if (flush) begin
                    pc_d    = branch_target;
                    ifid_d  = '0;
                    state_d = S_RUN;
                end else if (!stall) begin
                    ifid_d.inst  = '0;
                    ifid_d.valid = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_to_mem   = pc_q;
    assign ifid_inst   = ifid_q.inst;
    assign ifid_pc1    = ifid_q.pc1;
    assign ifid_valid  = ifid_q.valid;
    assign halted      = (state_q == S_HALT);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/flush traffic,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [9:0]  branch_target = '0;
    logic [9:0]  pc_to_mem;
    logic [15:0] inst_from_mem;
    logic [15:0] ifid_inst;
    logic [9:0]  ifid_pc1;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:1023];

    int n_chk = 0;
    int n_fail = 0;

    // Reference state
    int          m_pc, m_pc1, m_cnt, m_mode;
    logic [15:0] m_inst;
    bit          m_valid;

    always #5 clk = ~clk;

    assign inst_from_mem = mem[pc_to_mem];

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_target(branch_target), .pc_to_mem(pc_to_mem),
        .inst_from_mem(inst_from_mem), .ifid_inst(ifid_inst),
        .ifid_pc1(ifid_pc1), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_pc1 = 0; m_cnt = 0; m_mode = M_IDLE;
        m_inst = 16'h0; m_valid = 1'b0;
    endtask

    // One clock edge of the fetch rules, evaluated on the pre-edge values.
    task automatic model_edge(bit s, bit f, int bt);
        logic [15:0] word;
        word = mem[m_pc];
        if (m_mode == M_IDLE) begin
            m_mode = M_RUN;
        end else if (f) begin
            m_pc = bt; m_inst = 16'h0; m_valid = 1'b0; m_pc1 = 0;
            m_mode = M_RUN;
        end else if (!s) begin
            if (m_mode == M_RUN) begin
                m_inst = word; m_valid = 1'b1;
                m_pc1 = (m_pc + 1) % 1024;
                if (m_cnt < 65535) m_cnt++;
                if (word == 16'hFFFF) m_mode = M_HALT;
                else m_pc = (m_pc + 1) % 1024;
            end else begin
                m_inst = 16'h0; m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".pc"},    32'(pc_to_mem),   32'(m_pc));
        chk({tag, ".inst"},  32'(ifid_inst),   32'(m_inst));
        chk({tag, ".valid"}, 32'(ifid_valid),  32'(m_valid));
        if (m_valid) chk({tag, ".pc1"}, 32'(ifid_pc1), 32'(m_pc1));
        chk({tag, ".halted"}, 32'(halted),     32'(m_mode == M_HALT));
        chk({tag, ".count"}, 32'(fetch_count), 32'(m_cnt));
    endtask

    // Called just after a falling edge; checks 1 time unit after the rising edge.
    task automatic cycle(string tag, bit s, bit f, logic [9:0] bt);
        stall = s; flush = f; branch_target = bt;
        model_edge(s, f, int'(bt));
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, ".pc"},     32'(pc_to_mem),   32'h0);
        chk({tag, ".inst"},   32'(ifid_inst),   32'h0);
        chk({tag, ".pc1"},    32'(ifid_pc1),    32'h0);
        chk({tag, ".valid"},  32'(ifid_valid),  32'h0);
        chk({tag, ".halted"}, 32'(halted),      32'h0);
        chk({tag, ".count"},  32'(fetch_count), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w == 16'hFFFF) w = 16'h1234;
            mem[i] = w;
        end
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        mem[3] = 16'h4444; mem[4] = 16'h5555; mem[5] = 16'hFFFF;

        // Reset values while rst held
        model_reset();
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1) IDLE cycle then sequential fetch, with 2-cycle stall on 2222
        cycle("idle", 1'b1, 1'b1, 10'h155);
        chk("idle.pc_fixed", 32'(pc_to_mem), 32'h0);
        cycle("f1", 1'b0, 1'b0, 10'h0);
        cycle("f2", 1'b0, 1'b0, 10'h0);
        chk("f2.inst_fixed", 32'(ifid_inst), 32'h2222);
        cycle("st1", 1'b1, 1'b0, 10'h0);
        cycle("st2", 1'b1, 1'b0, 10'h0);
        chk("st2.pc_fixed", 32'(pc_to_mem), 32'h2);
        cycle("f3", 1'b0, 1'b0, 10'h0);
        chk("f3.inst_fixed", 32'(ifid_inst), 32'h3333);
        chk("f3.cnt_fixed", 32'(fetch_count), 32'h3);

        // 3) flush beats stall
        cycle("fl_st", 1'b1, 1'b1, 10'h200);
        chk("fl_st.pc_fixed", 32'(pc_to_mem), 32'h200);
        cycle("fl_f", 1'b0, 1'b0, 10'h0);
        chk("fl_f.pc1_fixed", 32'(ifid_pc1), 32'h201);

        // 4) wrap at top of address space
        cycle("wr_fl", 1'b0, 1'b1, 10'h3FF);
        cycle("wr_f", 1'b0, 1'b0, 10'h0);
        chk("wr.pc1_fixed", 32'(ifid_pc1), 32'h0);
        chk("wr.pc_fixed", 32'(pc_to_mem), 32'h0);

        // 5) halt at address 5, stalled once, then bubble, then redirect
        cycle("h_fl", 1'b0, 1'b1, 10'h3);
        cycle("h_f3", 1'b0, 1'b0, 10'h0);
        cycle("h_f4", 1'b0, 1'b0, 10'h0);
        cycle("h_f5", 1'b0, 1'b0, 10'h0);
        chk("halt.inst_fixed", 32'(ifid_inst), 32'hFFFF);
        chk("halt.halted_fixed", 32'(halted), 32'h1);
        cycle("h_stall", 1'b1, 1'b0, 10'h0);
        cycle("h_bub1", 1'b0, 1'b0, 10'h0);
        chk("halt.bubble_fixed", 32'(ifid_valid), 32'h0);
        cycle("h_bub2", 1'b0, 1'b0, 10'h0);
        chk("halt.pc_fixed", 32'(pc_to_mem), 32'h5);
        cycle("h_bub3", 1'b1, 1'b0, 10'h0);
        cycle("h_redir", 1'b0, 1'b1, 10'h0);
        chk("redir.halted_fixed", 32'(halted), 32'h0);
        cycle("h_res", 1'b0, 1'b0, 10'h0);
        chk("resume.inst_fixed", 32'(ifid_inst), 32'h1111);

        // 6) async reset mid-run at pc=7, count=7
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        mem[5] = 16'h5A5A;
        cycle("r_idle", 1'b0, 1'b0, 10'h0);
        for (int i = 0; i < 7; i++) cycle("r_run", 1'b0, 1'b0, 10'h0);
        chk("r_run.pc_fixed", 32'(pc_to_mem), 32'h7);
        chk("r_run.cnt_fixed", 32'(fetch_count), 32'h7);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Random traffic with sprinkled halt opcodes
        for (int i = 0; i < 1024; i++)
            if ($urandom_range(0, 19) == 0) mem[i] = 16'hFFFF;
        for (int i = 0; i < 1500; i++) begin
            bit s, f;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 9) == 0);
            cycle("rand", s, f, 10'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Time limit guard
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
